// File: rtl/pipe_issue_pkg.sv
// Shared widths and the operand tuple type for the pipeline feeder.
// Imported by op_fifo and pipe_issue.
package pipe_issue_pkg;

  localparam int OP_W            = 9;
  localparam int RES_W           = 10;
  localparam int DEFAULT_LATENCY = 4;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [OP_W-1:0] c;
    logic [OP_W-1:0] d;
    logic [OP_W-1:0] e;
  } op_tuple_t;

endpackage

// File: rtl/op_fifo.sv
// Synchronous FIFO of operand tuples with sync reset and flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module op_fifo
  import pipe_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  op_tuple_t                wr_data,
  output op_tuple_t                rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  op_tuple_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is left unreset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_issue.sv
// Feeder for the 4-stage arithmetic pipeline: buffers tuples, issues one per cycle,
// tracks in-flight work and qualifies H. Optional counters: PIPE_ISSUE_STATS_EN.
module pipe_issue
  import pipe_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_a,
  input  logic [OP_W-1:0]          in_b,
  input  logic [OP_W-1:0]          in_c,
  input  logic [OP_W-1:0]          in_d,
  input  logic [OP_W-1:0]          in_e,
  output logic [OP_W-1:0]          op_a,
  output logic [OP_W-1:0]          op_b,
  output logic [OP_W-1:0]          op_c,
  output logic [OP_W-1:0]          op_d,
  output logic [OP_W-1:0]          op_e,
  input  logic [RES_W-1:0]         pipe_h,
  output logic                     res_valid,
  output logic [RES_W-1:0]         res_h,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef PIPE_ISSUE_STATS_EN
  ,
  output logic [15:0]              issued_cnt,
  output logic [15:0]              flushed_cnt
`endif
);

  op_tuple_t       in_tuple;
  op_tuple_t       head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            issue;
  logic [LATENCY:0] vld;

  assign in_tuple = '{a: in_a, b: in_b, c: in_c, d: in_d, e: in_e};
  assign in_ready = !rst && !fifo_full;
  assign issue    = !fifo_empty && !flush;

  op_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (in_valid && in_ready),
    .pop     (issue),
    .wr_data (in_tuple),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The pipeline has no valid of its own, so vld[k] shadows each issued tuple
  // until H for it is stable; flush keeps op_* and res_h but forgets the work.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      op_c      <= '0;
      op_d      <= '0;
      op_e      <= '0;
      vld       <= '0;
      res_valid <= 1'b0;
      res_h     <= '0;
    end else if (flush) begin
      vld       <= '0;
      res_valid <= 1'b0;
    end else begin
      if (issue) begin
        op_a <= head.a;
        op_b <= head.b;
        op_c <= head.c;
        op_d <= head.d;
        op_e <= head.e;
      end
      vld       <= {vld[LATENCY-1:0], issue};
      res_valid <= vld[LATENCY];
      if (vld[LATENCY]) begin
        res_h <= pipe_h;
      end
    end
  end

`ifdef PIPE_ISSUE_STATS_EN
  logic [15:0] flush_drop;

  // Work discarded by a flush is whatever is queued plus whatever is in flight.
  always_comb begin
    flush_drop = 16'(fifo_count);
    for (int k = 0; k <= LATENCY; k++) begin
      flush_drop = flush_drop + 16'(vld[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_cnt  <= '0;
      flushed_cnt <= '0;
    end else begin
      if (issue) begin
        issued_cnt <= issued_cnt + 16'd1;
      end
      if (flush) begin
        flushed_cnt <= flushed_cnt + flush_drop;
      end
    end
  end
`endif

endmodule
